// File: rtl/md_defs.sv
// -----------------------------------------------------------------------------
// md_defs
//   Shared definitions for the multiply/divide unit and its users
//   (decode, hazard logic).
//   - md_op_e    : operation code carried on md_unit.md_op
//   - md_state_e : sequencer state encoding
//   - md_result_t: pending HI/LO pair plus a commit flag
//   - default busy-cycle counts for MULT/MULTU and DIV/DIVU
//   - neg32      : two's-complement negate helper
// -----------------------------------------------------------------------------
package md_defs;

   typedef enum logic [2:0] {
      MD_NOP   = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        commit;  // 0 for divide-by-zero: HI/LO left untouched
   } md_result_t;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//   Multi-cycle MIPS multiply/divide sequencer owning the HI/LO pair.
//   The result is computed combinationally from rs/rt in the launch cycle,
//   parked in pending registers, and committed to HI/LO when the busy
//   counter expires, so dependent instructions see the documented latency.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low reset
//   start  in   1   launch md_op this cycle
//   md_op  in   3   operation (md_defs::md_op_e)
//   rs     in  32   operand A / dividend / MTHI-MTLO source
//   rt     in  32   operand B / divisor
//   busy   out  1   multi-cycle operation in progress (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
// -----------------------------------------------------------------------------
module md_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   md_result_t        pend_q, pend_d;

   // ---------------------------------------------------------------------------
   // Arithmetic on the live operands; only sampled in the launch cycle.
   // ---------------------------------------------------------------------------
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        a_mag, b_mag, b_div, q_mag, r_mag;
   logic [31:0]        quo_s, rem_s, rt_div, quo_u, rem_u;

   always_comb begin
      prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
      prod_u = {32'd0, rs} * {32'd0, rt};

      // Signed divide via magnitudes: truncation toward zero falls out
      // naturally and 0x80000000 / -1 needs no special case (the magnitude
      // 0x80000000 negates back to itself).
      a_mag = rs[31] ? neg32(rs) : rs;
      b_mag = rt[31] ? neg32(rt) : rt;
      // Divisors forced non-zero so the divider never sees 0; the zero case
      // is handled by clearing the commit flag instead.
      b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag = a_mag / b_div;
      r_mag = a_mag % b_div;
      quo_s = (rs[31] ^ rt[31]) ? neg32(q_mag) : q_mag;
      rem_s = rs[31] ? neg32(r_mag) : r_mag;

      rt_div = (rt == 32'd0) ? 32'd1 : rt;
      quo_u  = rs / rt_div;
      rem_u  = rs % rt_div;
   end

   // ---------------------------------------------------------------------------
   // Sequencer: next-state and register updates.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               case (md_op_e'(md_op))
                  MD_MULT: begin
                     pend_d  = '{hi: prod_s[63:32], lo: prod_s[31:0], commit: 1'b1};
                     count_d = CNT_W'(MULT_CYCLES);
                     state_d = RUN;
                  end
                  MD_MULTU: begin
                     pend_d  = '{hi: prod_u[63:32], lo: prod_u[31:0], commit: 1'b1};
                     count_d = CNT_W'(MULT_CYCLES);
                     state_d = RUN;
                  end
                  MD_DIV: begin
                     pend_d  = '{hi: rem_s, lo: quo_s, commit: (rt != 32'd0)};
                     count_d = CNT_W'(DIV_CYCLES);
                     state_d = RUN;
                  end
                  MD_DIVU: begin
                     pend_d  = '{hi: rem_u, lo: quo_u, commit: (rt != 32'd0)};
                     count_d = CNT_W'(DIV_CYCLES);
                     state_d = RUN;
                  end
                  MD_MTHI: hi_d = rs;
                  MD_MTLO: lo_d = rs;
                  default: ;  // NOP and unused encodings have no effect
               endcase
            end
         end
         RUN: begin
            // start is deliberately not looked at here: a launch while busy
            // is dropped and the pending operation carries on.
            if (count_q == CNT_W'(1)) begin
               if (pend_q.commit) begin
                  hi_d = pend_q.hi;
                  lo_d = pend_q.lo;
               end
               count_d = '0;
               state_d = IDLE;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from
         // pre-edge values regardless of statement order.
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
      end
   end

   // busy decodes a flop only, so there is no combinational path from start.
   assign busy = (state_q == RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

   // The pipeline is expected to stall instead of launching into a busy
   // unit; flag it when it happens anyway.
   a_no_start_while_busy : assert property (
      @(posedge clk) disable iff (!reset) !(start && busy)
   ) else $warning("md_unit: start while busy was ignored");

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit
//   Scoreboard bench for md_unit. The driver computes the architectural
//   HI/LO outcome of each launched op with plain 64-bit arithmetic and
//   queues it; a monitor sampling on the falling edge pops entries as the
//   unit accepts starts and checks busy timing, HI/LO hold and the result.
// -----------------------------------------------------------------------------
module tb_md_unit;
   import md_defs::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs = '0;
   logic [31:0] rt = '0;
   logic        busy;
   logic [31:0] hi, lo;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural reference: what HI/LO hold after the op, and for how many
   // cycles the unit reports busy.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] cur_hi, input logic [31:0] cur_lo);
      exp_t e;
      int ia, ib;
      longint sa, sb, p, q, r;
      longint unsigned ua, ub, pu;
      ia = a;  ib = b;
      sa = ia; sb = ib;
      ua = a;  ub = b;
      e.op = op; e.prev_hi = cur_hi; e.prev_lo = cur_lo;
      e.hi = cur_hi; e.lo = cur_lo; e.n = 0;
      case (op)
         MD_MULT:  begin p = sa * sb;  {e.hi, e.lo} = p;  e.n = MC; end
         MD_MULTU: begin pu = ua * ub; {e.hi, e.lo} = pu; e.n = MC; end
         MD_DIV: begin
            e.n = DC;
            if (b != 0) begin
               q = sa / sb; r = sa % sb;
               e.lo = q[31:0]; e.hi = r[31:0];
            end
         end
         MD_DIVU: begin
            e.n = DC;
            if (b != 0) begin
               e.lo = a / b; e.hi = a % b;
            end
         end
         MD_MTHI: e.hi = a;
         MD_MTLO: e.lo = a;
         default: ;
      endcase
      return e;
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   exp_t cur;
   bit   mon_active = 1'b0;
   int   mon_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         mon_active = 1'b0;
      end else begin
         if (mon_active) begin
            if (mon_cnt > 0) begin
               check("busy_during_op", 32'(busy), 32'd1);
               check("hi_held", hi, cur.prev_hi);
               check("lo_held", lo, cur.prev_lo);
               mon_cnt--;
            end else begin
               check("busy_after_op", 32'(busy), 32'd0);
               check("hi_result", hi, cur.hi);
               check("lo_result", lo, cur.lo);
               mon_active = 1'b0;
            end
         end else begin
            check("busy_idle", 32'(busy), 32'd0);
         end
         if (!mon_active && start) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_start: actual=start required=no_start (t=%0t)", $time);
            end else begin
               cur        = sb_q.pop_front();
               mon_cnt    = cur.n;
               mon_active = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
      exp_t e;
      e = model(op, a, b, m_hi, m_lo);
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
      n = e.n;
      start = 1'b1; md_op = op; rs = a; rt = b;
      @(posedge clk);
      #1;
      // Scramble operands after launch: they must have been captured.
      start = 1'b0; md_op = 3'($urandom_range(0, 7)); rs = $urandom; rt = $urandom;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      launch(op, a, b, n);
      idle_cycles(n);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;

      // Reset state
      @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle_cycles(1);

      // Directed multiply / divide cases
      issue(MD_MULT,  32'hFFFF_FFFE, 32'd3);
      issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
      issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
      issue(MD_DIVU,  32'd7,         32'd2);

      // Divide by zero leaves HI/LO alone
      issue(MD_MTHI,  32'h0000_0011, 32'd0);
      issue(MD_MTLO,  32'h0000_0022, 32'd0);
      issue(MD_DIV,   32'h0000_0005, 32'd0);
      issue(MD_DIVU,  32'h0000_0009, 32'd0);
      issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

      // Back-to-back moves, NOP and an unused encoding
      issue(MD_MTHI,  32'hDEAD_BEEF, 32'd0);
      issue(MD_MTLO,  32'h1234_5678, 32'd0);
      issue(MD_NOP,   32'hCAFE_F00D, 32'd1);
      issue(3'd7,     32'hCAFE_F00D, 32'd1);

      // Start during a running divide is dropped
      launch(MD_DIV, 32'd100, 32'd7, n);
      idle_cycles(3);
      start = 1'b1; md_op = MD_MULT; rs = 32'd9; rt = 32'd9;
      idle_cycles(1);
      start = 1'b0;
      idle_cycles(n - 4);

      // Reset in the middle of a multiply
      issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
      issue(MD_MTLO, 32'h5A5A_5A5A, 32'd0);
      launch(MD_MULT, 32'd1234, 32'd5678, n);
      idle_cycles(2);
      reset = 1'b0;
      #1;
      check("midop_reset_busy", 32'(busy), 32'd0);
      check("midop_reset_hi", hi, 32'd0);
      check("midop_reset_lo", lo, 32'd0);
      m_hi = '0;
      m_lo = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      issue(MD_MTHI, 32'h0BAD_CAFE, 32'd0);
      issue(MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

      // Randomised operations
      for (int i = 0; i < 60; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         issue(op, a, b);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end

      idle_cycles(3);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      check("monitor_idle", 32'(mon_active), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
